alu_flag_unit: RTL and testbench

Status-flag register and branch-condition evaluator directly downstream of the 8-bit ALU. Latches the ALU's C/V/N/Z outputs under a per-flag write mask and evaluates a 4-bit branch condition against the latched flags for the PC-select logic. A small flag save/restore stack preserves flags across the sample-timer interrupt entry and return.

---
 rtl/alu_flag_unit_pkg.sv | 34 +++
 rtl/alu_flag_unit_cond_eval.sv | 46 ++++
 rtl/alu_flag_unit.sv | 118 +++++++++++
 tb/tb_alu_flag_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_flag_unit_pkg.sv
// Shared constants for the ALU status-flag unit: flag bit positions,
// branch condition codes and sticky error bit positions.
package alu_flag_unit_pkg;

    // Bit positions inside the 4-bit {C,V,N,Z} flag vector
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    // Branch condition codes
    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    // Sticky error bit positions inside err {proto, underflow, overflow}
    localparam int ERR_OVF   = 0;
    localparam int ERR_UDF   = 1;
    localparam int ERR_PROTO = 2;

endpackage

// File: rtl/alu_flag_unit_cond_eval.sv
// Pure combinational branch-condition evaluator: condition code plus
// {C,V,N,Z} flags in, take out. Kept standalone so conditional-execute
// logic can reuse the same decode.
module flag_cond_eval
    import alu_flag_unit_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       take_o
);

    logic c_f;
    logic v_f;
    logic n_f;
    logic z_f;

    assign c_f = flags_i[FLAG_C];
    assign v_f = flags_i[FLAG_V];
    assign n_f = flags_i[FLAG_N];
    assign z_f = flags_i[FLAG_Z];

    // Decode the condition code against the supplied flags
    always_comb begin
        take_o = 1'b0;
        case (cond_i)
            COND_EQ: take_o = z_f;
            COND_NE: take_o = ~z_f;
            COND_CS: take_o = c_f;
            COND_CC: take_o = ~c_f;
            COND_MI: take_o = n_f;
            COND_PL: take_o = ~n_f;
            COND_VS: take_o = v_f;
            COND_VC: take_o = ~v_f;
            COND_HI: take_o = c_f & ~z_f;
            COND_LS: take_o = ~c_f | z_f;
            COND_GE: take_o = (n_f == v_f);
            COND_LT: take_o = (n_f != v_f);
            COND_GT: take_o = ~z_f & (n_f == v_f);
            COND_LE: take_o = z_f | (n_f != v_f);
            COND_AL: take_o = 1'b1;
            COND_NV: take_o = 1'b0;
            default: take_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_flag_unit.sv
// Status-flag register downstream of the 8-bit ALU. Latches C/V/N/Z under a
// per-flag write mask or a direct PSR load, keeps a small save/restore stack
// for interrupt entry/return, and reports sticky stack misuse errors.
// take is evaluated from the registered flags only; in-flight ALU results
// are never bypassed.
module alu_flag_unit
    import alu_flag_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_in,
    input  logic             v_in,
    input  logic             n_in,
    input  logic             z_in,
    input  logic [3:0]       flag_we,
    input  logic             psr_wr,
    input  logic [3:0]       psr_data,
    input  logic             push,
    input  logic             pop,
    input  logic [3:0]       cond,
    input  logic             err_clr,
    output logic [3:0]       flags,
    output logic             take,
    output logic [PTR_W:0]   depth,
    output logic             full,
    output logic             empty,
    output logic [2:0]       err
);

    localparam logic [PTR_W:0] DEPTH_MAX = (PTR_W+1)'(DEPTH);

    logic [3:0]       flags_q;
    logic [3:0]       flags_d;
    logic [PTR_W:0]   depth_q;
    logic [PTR_W:0]   depth_d;
    logic [2:0]       err_q;
    logic [2:0]       err_d;
    logic [3:0]       stack_q [DEPTH];

    logic             is_full;
    logic             is_empty;
    logic             push_ok;
    logic             pop_ok;
    logic [PTR_W-1:0] top_idx;
    logic [3:0]       alu_flags;
    logic [2:0]       err_ev;

    assign alu_flags = {c_in, v_in, n_in, z_in};

    // Next-state for flags, stack depth and sticky errors
    always_comb begin
        is_full  = (depth_q == DEPTH_MAX);
        is_empty = (depth_q == '0);
        // Simultaneous push and pop is a protocol error: neither side acts
        push_ok  = push & ~pop & ~is_full;
        pop_ok   = pop & ~push & ~is_empty;
        top_idx  = depth_q[PTR_W-1:0] - PTR_W'(1);

        // Restore beats PSR load beats masked ALU update
        if (pop_ok) begin
            flags_d = stack_q[top_idx];
        end else if (psr_wr) begin
            flags_d = psr_data;
        end else begin
            flags_d = (flags_q & ~flag_we) | (alu_flags & flag_we);
        end

        depth_d = depth_q;
        if (push_ok) begin
            depth_d = depth_q + (PTR_W+1)'(1);
        end else if (pop_ok) begin
            depth_d = depth_q - (PTR_W+1)'(1);
        end

        err_ev            = '0;
        err_ev[ERR_OVF]   = push & ~pop & is_full;
        err_ev[ERR_UDF]   = pop & ~push & is_empty;
        err_ev[ERR_PROTO] = push & pop;
        // A new error event in the same cycle as err_clr still lands
        err_d = (err_clr ? 3'b000 : err_q) | err_ev;
    end

    // Flag, depth and error registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
            depth_q <= '0;
            err_q   <= 3'b000;
        end else begin
            flags_q <= flags_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Stack storage saves the pre-update flags; contents need no reset
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            stack_q[depth_q[PTR_W-1:0]] <= flags_q;
        end
    end

    flag_cond_eval u_cond_eval (
        .cond_i  (cond),
        .flags_i (flags_q),
        .take_o  (take)
    );

    assign flags = flags_q;
    assign depth = depth_q;
    assign err   = err_q;
    assign full  = is_full;
    assign empty = is_empty;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Self-checking bench for alu_flag_unit: a reference model pushes the
// expected post-edge state into exp_q as each vector is driven; each test
// task pops and compares after the edge, plus directed constant checks.
module tb_alu_flag_unit;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int OBS_W = 13;

  logic           clk;
  logic           reset;
  logic           c_in, v_in, n_in, z_in;
  logic [3:0]     flag_we;
  logic           psr_wr;
  logic [3:0]     psr_data;
  logic           push, pop;
  logic [3:0]     cond;
  logic           err_clr;
  logic [3:0]     flags;
  logic           take;
  logic [PTR_W:0] depth;
  logic           full, empty;
  logic [2:0]     err;

  logic [OBS_W-1:0] exp_q[$];
  logic [3:0]       m_stk[$];
  logic [3:0]       m_flags;
  logic [2:0]       m_err;
  int               vec_cnt;
  int               miscmp;

  alu_flag_unit #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .c_in(c_in), .v_in(v_in), .n_in(n_in), .z_in(z_in),
    .flag_we(flag_we), .psr_wr(psr_wr), .psr_data(psr_data),
    .push(push), .pop(pop), .cond(cond), .err_clr(err_clr),
    .flags(flags), .take(take), .depth(depth),
    .full(full), .empty(empty), .err(err)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference branch decode: even codes are a base test, odd codes invert it
  function automatic logic ref_take(input logic [3:0] cd, input logic [3:0] f);
    logic c, v, n, z, base;
    c = f[3]; v = f[2]; n = f[1]; z = f[0];
    case (cd[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ cd[0];
  endfunction

  function automatic logic [OBS_W-1:0] obs();
    return {flags, take, depth, full, empty, err};
  endfunction

  // driver: apply one vector, advance the model, queue expected state
  task automatic step(input logic rst, input logic [3:0] ins, input logic [3:0] we,
                      input logic pw, input logic [3:0] pd, input logic pu,
                      input logic po, input logic [3:0] cd, input logic ec);
    logic [3:0] nf;
    logic [2:0] ev;
    int         sz;
    reset = rst; {c_in, v_in, n_in, z_in} = ins; flag_we = we;
    psr_wr = pw; psr_data = pd; push = pu; pop = po; cond = cd; err_clr = ec;
    if (rst) begin
      m_flags = 4'b0000; m_err = 3'b000; m_stk.delete();
    end else begin
      sz = m_stk.size();
      ev = 3'b000;
      if (pu && po) ev[2] = 1'b1;
      if (po && !pu && sz == 0) ev[1] = 1'b1;
      if (pu && !po && sz == DEPTH) ev[0] = 1'b1;
      if (po && !pu && sz > 0) begin
        nf = m_stk.pop_back();
      end else if (pw) begin
        nf = pd;
      end else begin
        for (int b = 0; b < 4; b++) nf[b] = we[b] ? ins[b] : m_flags[b];
      end
      if (pu && !po && sz < DEPTH) m_stk.push_back(m_flags);
      m_flags = nf;
      m_err = (ec ? 3'b000 : m_err) | ev;
    end
    sz = m_stk.size();
    exp_q.push_back({m_flags, ref_take(cd, m_flags), 3'(sz), sz == DEPTH, sz == 0, m_err});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [OBS_W-1:0] e;
    step(1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 4'd0, 0);
    e = exp_q.pop_front(); vec_cnt++;
    if (obs() !== e) begin miscmp++; $display("FAIL reset_sb: got %h want %h", obs(), e); end
    vec_cnt++;
    if ({flags, depth, full, empty, err} !== {4'b0000, 3'd0, 1'b0, 1'b1, 3'b000}) begin
      miscmp++; $display("FAIL reset_const: flags=%b depth=%0d full=%b empty=%b err=%b", flags, depth, full, empty, err);
    end
  endtask

  task automatic test_flag_we();
    logic [OBS_W-1:0] e;
    step(0, 4'b1010, 4'b1111, 0, 4'h0, 0, 0, 4'd4, 0);
    e = exp_q.pop_front(); vec_cnt++;
    if (obs() !== e) begin miscmp++; $display("FAIL flag_we_sb: got %h want %h", obs(), e); end
    vec_cnt++;
    if ({flags, take} !== {4'b1010, 1'b1}) begin miscmp++; $display("FAIL flag_we_mi: flags=%b take=%b want 1010/1", flags, take); end
    cond = 4'd0; #1; vec_cnt++;
    if (take !== 1'b0) begin miscmp++; $display("FAIL flag_we_eq: take=%b want 0", take); end
    cond = 4'd11; #1; vec_cnt++;
    if (take !== 1'b1) begin miscmp++; $display("FAIL flag_we_lt: take=%b want 1", take); end
    step(0, 4'b0001, 4'b0001, 0, 4'h0, 0, 0, 4'd8, 0);
    e = exp_q.pop_front(); vec_cnt++;
    if (obs() !== e) begin miscmp++; $display("FAIL mask_sb: got %h want %h", obs(), e); end
    vec_cnt++;
    if ({flags, take} !== {4'b1011, 1'b0}) begin miscmp++; $display("FAIL mask_hi: flags=%b take=%b want 1011/0", flags, take); end
    cond = 4'd9; #1; vec_cnt++;
    if (take !== 1'b1) begin miscmp++; $display("FAIL mask_ls: take=%b want 1", take); end
  endtask

  task automatic test_cond_table();
    logic [OBS_W-1:0] e;
    for (int i = 0; i < 48; i++) begin
      step(0, 4'h0, 4'h0, 1, 4'($urandom_range(0, 15)), 0, 0, 4'(i % 16), 0);
      e = exp_q.pop_front(); vec_cnt++;
      if (obs() !== e) begin miscmp++; $display("FAIL cond_sb[%0d]: got %h want %h", i, obs(), e); end
    end
  endtask

  task automatic test_push_pop_psr();
    logic [OBS_W-1:0] e;
    step(0, 4'h0, 4'h0, 1, 4'b0110, 0, 0, 4'd0, 0);
    e = exp_q.pop_front();
    step(0, 4'h0, 4'h0, 1, 4'b0001, 1, 0, 4'd0, 0);
    e = exp_q.pop_front(); vec_cnt++;
    if (obs() !== e) begin miscmp++; $display("FAIL push_psr_sb: got %h want %h", obs(), e); end
    vec_cnt++;
    if ({flags, depth} !== {4'b0001, 3'd1}) begin miscmp++; $display("FAIL push_psr: flags=%b depth=%0d want 0001/1", flags, depth); end
    step(0, 4'h0, 4'b1111, 1, 4'b1111, 0, 1, 4'd0, 0);
    e = exp_q.pop_front(); vec_cnt++;
    if (obs() !== e) begin miscmp++; $display("FAIL pop_sb: got %h want %h", obs(), e); end
    vec_cnt++;
    if ({flags, depth, empty} !== {4'b0110, 3'd0, 1'b1}) begin miscmp++; $display("FAIL pop_restore: flags=%b depth=%0d empty=%b want 0110/0/1", flags, depth, empty); end
  endtask

  task automatic test_over_underflow();
    logic [OBS_W-1:0] e;
    step(1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 4'd0, 0); e = exp_q.pop_front();
    step(0, 4'h0, 4'h0, 1, 4'b0101, 0, 0, 4'd0, 0); e = exp_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      step(0, 4'h0, 4'h0, 1, 4'(k + 1), 1, 0, 4'd2, 0);
      e = exp_q.pop_front(); vec_cnt++;
      if (obs() !== e) begin miscmp++; $display("FAIL ovf_sb[%0d]: got %h want %h", k, obs(), e); end
    end
    vec_cnt++;
    if ({depth, full, err} !== {3'd4, 1'b1, 3'b001}) begin miscmp++; $display("FAIL ovf: depth=%0d full=%b err=%b want 4/1/001", depth, full, err); end
    for (int k = 0; k < 5; k++) begin
      step(0, 4'h0, 4'h0, 0, 4'h0, 0, 1, 4'd3, 0);
      e = exp_q.pop_front(); vec_cnt++;
      if (obs() !== e) begin miscmp++; $display("FAIL udf_sb[%0d]: got %h want %h", k, obs(), e); end
    end
    vec_cnt++;
    if ({flags, depth, empty, err} !== {4'b0101, 3'd0, 1'b1, 3'b011}) begin
      miscmp++; $display("FAIL udf: flags=%b depth=%0d empty=%b err=%b want 0101/0/1/011", flags, depth, empty, err);
    end
    step(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 4'd0, 1);
    e = exp_q.pop_front(); vec_cnt++;
    if (err !== 3'b000 || obs() !== e) begin miscmp++; $display("FAIL err_clr: got %h want %h", obs(), e); end
    step(0, 4'h0, 4'h0, 0, 4'h0, 0, 1, 4'd0, 1);
    e = exp_q.pop_front(); vec_cnt++;
    if (err !== 3'b010 || obs() !== e) begin miscmp++; $display("FAIL err_clr_vs_event: got %h want %h", obs(), e); end
  endtask

  task automatic test_back_to_back();
    logic [OBS_W-1:0] e;
    step(1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 4'd0, 0); e = exp_q.pop_front();
    step(0, 4'h0, 4'h0, 1, 4'b1000, 1, 0, 4'd0, 0); e = exp_q.pop_front();
    step(0, 4'h0, 4'h0, 1, 4'b0100, 1, 0, 4'd0, 0); e = exp_q.pop_front();
    step(0, 4'b1111, 4'b1111, 0, 4'h0, 1, 1, 4'd0, 0);
    e = exp_q.pop_front(); vec_cnt++;
    if (obs() !== e) begin miscmp++; $display("FAIL pushpop_sb: got %h want %h", obs(), e); end
    vec_cnt++;
    if ({depth, flags, err} !== {3'd2, 4'b1111, 3'b100}) begin miscmp++; $display("FAIL pushpop: depth=%0d flags=%b err=%b want 2/1111/100", depth, flags, err); end
  endtask

  task automatic test_mid_reset();
    logic [OBS_W-1:0] e;
    step(1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 4'd0, 0); e = exp_q.pop_front();
    step(0, 4'h0, 4'h0, 1, 4'b1111, 1, 1, 4'd0, 0); e = exp_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      step(0, 4'h0, 4'h0, 0, 4'h0, 1, 0, 4'd0, 0); e = exp_q.pop_front();
    end
    vec_cnt++;
    if ({depth, flags} !== {3'd3, 4'b1111}) begin miscmp++; $display("FAIL mid_reset_pre: depth=%0d flags=%b want 3/1111", depth, flags); end
    step(1, 4'b1111, 4'b1111, 1, 4'b1010, 1, 0, 4'd0, 1);
    e = exp_q.pop_front(); vec_cnt++;
    if ({flags, depth, empty, err} !== {4'b0000, 3'd0, 1'b1, 3'b000} || obs() !== e) begin
      miscmp++; $display("FAIL mid_reset: got %h want %h", obs(), e);
    end
  endtask

  task automatic test_random();
    logic [OBS_W-1:0] e;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
      e = exp_q.pop_front(); vec_cnt++;
      if (obs() !== e) begin miscmp++; $display("FAIL random_sb[%0d]: got %h want %h", i, obs(), e); end
    end
  endtask

  initial begin
    vec_cnt = 0; miscmp = 0;
    m_flags = 4'b0000; m_err = 3'b000;
    reset = 1'b1; {c_in, v_in, n_in, z_in} = 4'h0; flag_we = 4'h0;
    psr_wr = 1'b0; psr_data = 4'h0; push = 1'b0; pop = 1'b0;
    cond = 4'd0; err_clr = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_flag_we();
    test_cond_table();
    test_push_pop_psr();
    test_over_underflow();
    test_back_to_back();
    test_mid_reset();
    test_random();
    vec_cnt++;
    if (exp_q.size() != 0) begin miscmp++; $display("FAIL queue_drain: %0d left want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
